// File: rtl/aux_period_capture.sv
// Measures aux data-island (ADE) periods on the pixel clock and writes the
// horizontal start count of every complete packet into the aux send FIFO.
module aux_period_capture #(
    parameter int PKT_LEN = 32,
    parameter int HCNT_W  = 12,
    parameter int CNT_W   = 4
) (
    input  logic              fifo_clk,
    input  logic              sys_rst,
    input  logic              hsync,
    input  logic              vde,
    input  logic              ade,
    input  logic              ax_full,
    input  logic              err_clr,
    output logic [HCNT_W-1:0] axdin,
    output logic              ax_wr_en,
    output logic [CNT_W-1:0]  ade_num,
    output logic              ade_num_vld,
    output logic              ovf_err,
    output logic              fmt_err
);

    localparam int PC_W = $clog2(PKT_LEN);
    localparam logic [PC_W-1:0]   PC_LAST = PC_W'(PKT_LEN - 1);
    localparam logic [HCNT_W-1:0] HMAX    = {HCNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CMAX    = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } state_t;

    state_t            state_q, state_n;
    logic [PC_W-1:0]   pcnt_q, pcnt_n;
    logic [HCNT_W-1:0] start_q, start_n;
    logic [HCNT_W-1:0] hcnt_q;
    logic              hsync_q;
    logic [CNT_W-1:0]  line_cnt_q;
    logic              commit;
    logic              fmt_set;
    logic              hs_rise;
    logic              wr_ok;
    logic [CNT_W-1:0]  line_inc;

    assign hs_rise  = hsync & ~hsync_q;
    assign wr_ok    = commit & ~ax_full;
    assign line_inc = (line_cnt_q == CMAX) ? line_cnt_q : line_cnt_q + CNT_W'(1);

    // pcnt==0 inside PKT means the previous packet just committed; the next
    // contiguous packet takes its start on its own first cycle.
    always_comb begin
        state_n = state_q;
        pcnt_n  = pcnt_q;
        start_n = start_q;
        commit  = 1'b0;
        fmt_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (ade && !vde) begin
                    state_n = PKT;
                    start_n = hcnt_q;
                    pcnt_n  = PC_W'(1);
                end
            end
            PKT: begin
                if (vde) begin
                    fmt_set = 1'b1;
                    state_n = IDLE;
                    pcnt_n  = '0;
                end else if (ade) begin
                    if (pcnt_q == PC_LAST) begin
                        commit = 1'b1;
                        pcnt_n = '0;
                    end else begin
                        if (pcnt_q == '0) start_n = hcnt_q;
                        pcnt_n = pcnt_q + PC_W'(1);
                    end
                end else begin
                    fmt_set = (pcnt_q != '0);
                    state_n = IDLE;
                    pcnt_n  = '0;
                end
            end
            default: begin
                state_n = IDLE;
                pcnt_n  = '0;
            end
        endcase
    end

    always_ff @(posedge fifo_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            pcnt_q      <= '0;
            start_q     <= '0;
            hcnt_q      <= '0;
            hsync_q     <= 1'b0;
            line_cnt_q  <= '0;
            axdin       <= '0;
            ax_wr_en    <= 1'b0;
            ade_num     <= '0;
            ade_num_vld <= 1'b0;
            ovf_err     <= 1'b0;
            fmt_err     <= 1'b0;
        end else begin
            state_q <= state_n;
            pcnt_q  <= pcnt_n;
            start_q <= start_n;
            hsync_q <= hsync;

            if (hs_rise) hcnt_q <= '0;
            else if (hcnt_q != HMAX) hcnt_q <= hcnt_q + HCNT_W'(1);

            ax_wr_en <= wr_ok;
            if (wr_ok) axdin <= start_q;

            // A commit coinciding with the line boundary belongs to the new line.
            ade_num_vld <= hs_rise;
            if (hs_rise) begin
                ade_num    <= line_cnt_q;
                line_cnt_q <= wr_ok ? CNT_W'(1) : '0;
            end else if (wr_ok) begin
                line_cnt_q <= line_inc;
            end

            if (commit && ax_full) ovf_err <= 1'b1;
            else if (err_clr)      ovf_err <= 1'b0;

            if (fmt_set)      fmt_err <= 1'b1;
            else if (err_clr) fmt_err <= 1'b0;
        end
    end

endmodule
